// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants for the pipeline stage registers
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam int EXC_NONE = 0;
  localparam int EXC_INT  = 0;
  localparam int EXC_ADEL = 4;
  localparam int EXC_ADES = 5;
  localparam int EXC_RI   = 10;
  localparam int EXC_OV   = 12;

endpackage

// File: rtl/en_clr_reg.sv
// rtl/en_clr_reg.sv - register with sync active-low reset, sync clear and load enable
module en_clr_reg #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!resetn)  r_q <= RST_VAL;
    else if (clr) r_q <= CLR_VAL;
    else if (en)  r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall and flush
// Optional stall/bubble counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          PAYLOAD_W        = 32,
  parameter int          EXC_W            = 5,
  parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
  parameter logic [31:0] RESET_PC         = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 EN,
  input  logic                 flush,
  input  logic [31:0]          Instr,
  input  logic [31:0]          pc,
  input  logic                 valid,
  input  logic                 bd,
  input  logic [EXC_W-1:0]     exc,
  input  logic [PAYLOAD_W-1:0] payload,
  output logic [31:0]          Instr_out,
  output logic [31:0]          pc_out,
  output logic                 valid_out,
  output logic                 bd_out,
  output logic [EXC_W-1:0]     exc_out,
  output logic [PAYLOAD_W-1:0] payload_out,
  output logic                 bubble_out
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          bubble_cnt
`endif
);

  localparam int DATA_W = 32 + 1 + EXC_W + PAYLOAD_W;
  localparam logic [DATA_W-1:0] DATA_ZERO =
    {NOP_INSTR, 1'b0, EXC_W'(EXC_NONE), {PAYLOAD_W{1'b0}}};

  // bd, pc and bubble still load on a flush, so flush acts as a load for them
  logic              w_load;
  logic              w_pc_clr;
  logic [DATA_W-1:0] w_data_d;
  logic [DATA_W-1:0] w_data_q;

  assign w_load   = EN | flush;
  assign w_pc_clr = flush & ~KEEP_PC_ON_FLUSH;
  assign w_data_d = {Instr, valid, exc, payload};

  en_clr_reg #(.WIDTH(DATA_W), .RST_VAL(DATA_ZERO), .CLR_VAL(DATA_ZERO)) u_data (
    .clk(clk), .resetn(reset), .clr(flush), .en(EN), .d(w_data_d), .q(w_data_q)
  );

  en_clr_reg #(.WIDTH(32), .RST_VAL(RESET_PC), .CLR_VAL(32'h0)) u_pc (
    .clk(clk), .resetn(reset), .clr(w_pc_clr), .en(w_load), .d(pc), .q(pc_out)
  );

  en_clr_reg #(.WIDTH(1), .RST_VAL(1'b0), .CLR_VAL(1'b0)) u_bd (
    .clk(clk), .resetn(reset), .clr(1'b0), .en(w_load), .d(bd), .q(bd_out)
  );

  en_clr_reg #(.WIDTH(1), .RST_VAL(1'b0), .CLR_VAL(1'b0)) u_bubble (
    .clk(clk), .resetn(reset), .clr(1'b0), .en(w_load), .d(flush), .q(bubble_out)
  );

  assign {Instr_out, valid_out, exc_out, payload_out} = w_data_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end else if (!EN) begin
      r_stall_cnt  <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int          PW   = 32;
  localparam int          EW   = 5;
  localparam bit          KEEP = 1'b1;
  localparam logic [31:0] RPC  = 32'h0000_3000;

  typedef struct packed {
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic          valid;
    logic          bd;
    logic [EW-1:0] exc;
    logic [PW-1:0] payload;
    logic          bubble;
  } out_t;

  logic          clk = 1'b0;
  logic          reset, EN, flush, valid, bd;
  logic [31:0]   Instr, pc;
  logic [EW-1:0] exc;
  logic [PW-1:0] payload;
  logic [31:0]   Instr_out, pc_out;
  logic          valid_out, bd_out, bubble_out;
  logic [EW-1:0] exc_out;
  logic [PW-1:0] payload_out;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(.PAYLOAD_W(PW), .EXC_W(EW), .KEEP_PC_ON_FLUSH(KEEP), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .EN(EN), .flush(flush),
    .Instr(Instr), .pc(pc), .valid(valid), .bd(bd), .exc(exc), .payload(payload),
    .Instr_out(Instr_out), .pc_out(pc_out), .valid_out(valid_out), .bd_out(bd_out),
    .exc_out(exc_out), .payload_out(payload_out), .bubble_out(bubble_out)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  out_t        w_obs;
  out_t        m_state;
  out_t        exp_q[$];
  out_t        got;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_bubble = '0;

  assign w_obs = {Instr_out, pc_out, valid_out, bd_out, exc_out, payload_out, bubble_out};

  function automatic out_t model(input out_t cur, input logic rst, input logic en, input logic fl,
                                 input logic [31:0] ins, input logic [31:0] pcv, input logic v,
                                 input logic b, input logic [EW-1:0] e, input logic [PW-1:0] p);
    out_t n;
    n = cur;
    if (!rst)     n = '{instr: 32'h0, pc: RPC, valid: 1'b0, bd: 1'b0, exc: '0, payload: '0, bubble: 1'b0};
    else if (fl)  n = '{instr: 32'h0, pc: (KEEP ? pcv : 32'h0), valid: 1'b0, bd: b, exc: '0, payload: '0, bubble: 1'b1};
    else if (en)  n = '{instr: ins, pc: pcv, valid: v, bd: b, exc: e, payload: p, bubble: 1'b0};
    return n;
  endfunction

  // Applies one cycle of stimulus and queues the outputs expected after the edge
  task automatic drive_cycle(input logic rst, input logic en, input logic fl,
                             input logic [31:0] ins, input logic [31:0] pcv, input logic v,
                             input logic b, input logic [EW-1:0] e, input logic [PW-1:0] p);
    reset = rst; EN = en; flush = fl; Instr = ins; pc = pcv; valid = v; bd = b; exc = e; payload = p;
    m_state = model(m_state, rst, en, fl, ins, pcv, v, b, e, p);
    exp_q.push_back(m_state);
    if (!rst)     begin m_stall = '0; m_bubble = '0; end
    else if (fl)  m_bubble = m_bubble + 32'd1;
    else if (!en) m_stall = m_stall + 32'd1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 32'h2408_0001, 32'h3004, 1'b1, 1'b1, 5'd4, 32'h1111_2222);
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if (w_obs !== got) begin errors++; $display("FAIL reset obs=%h exp=%h", w_obs, got); end
    end
    checks++;
    if (Instr_out !== 32'h0 || pc_out !== 32'h3000 || valid_out !== 1'b0 || bubble_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_const instr=%h pc=%h valid=%b bubble=%b exp 0/3000/0/0", Instr_out, pc_out, valid_out, bubble_out);
    end
  endtask

  task automatic test_load;
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h2408_0001, 32'h3004, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    checks++;
    if (w_obs !== got) begin errors++; $display("FAIL load obs=%h exp=%h", w_obs, got); end
    checks++;
    if (Instr_out !== 32'h2408_0001 || pc_out !== 32'h3004 || payload_out !== 32'hDEAD_BEEF || valid_out !== 1'b1 || bubble_out !== 1'b0) begin
      errors++;
      $display("FAIL load_const instr=%h pc=%h payload=%h valid=%b bubble=%b", Instr_out, pc_out, payload_out, valid_out, bubble_out);
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h3008, 1'b0, 1'b1, 5'd12, 32'h0);
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if (w_obs !== got) begin errors++; $display("FAIL stall obs=%h exp=%h", w_obs, got); end
      checks++;
      if (Instr_out !== 32'h2408_0001 || pc_out !== 32'h3004) begin
        errors++;
        $display("FAIL stall_hold instr=%h pc=%h exp 24080001/3004", Instr_out, pc_out);
      end
    end
  endtask

  task automatic test_flush_stall;
    logic [31:0] pcs [2];
    pcs[0] = 32'h3010;
    pcs[1] = 32'h3014;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, 32'h1234_5678, pcs[i], 1'b1, 1'b1, 5'd10, 32'h0000_0055);
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if (w_obs !== got) begin errors++; $display("FAIL flush obs=%h exp=%h", w_obs, got); end
      checks++;
      if (Instr_out !== 32'h0 || valid_out !== 1'b0 || bubble_out !== 1'b1 || bd_out !== 1'b1 ||
          pc_out !== (KEEP ? pcs[i] : 32'h0) || exc_out !== '0) begin
        errors++;
        $display("FAIL flush_const instr=%h valid=%b bubble=%b bd=%b pc=%h exc=%h", Instr_out, valid_out, bubble_out, bd_out, pc_out, exc_out);
      end
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h4000, 1'b1, 1'b0, 5'd5, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    checks++;
    if (w_obs !== got || bubble_out !== 1'b1) begin errors++; $display("FAIL bubble_hold obs=%h exp=%h", w_obs, got); end
  endtask

  task automatic test_invalid_load;
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h2408_0002, 32'h3018, 1'b0, 1'b0, 5'd12, 32'h8000_0001);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    checks++;
    if (w_obs !== got) begin errors++; $display("FAIL invalid_load obs=%h exp=%h", w_obs, got); end
    checks++;
    if (valid_out !== 1'b0 || bubble_out !== 1'b0 || exc_out !== 5'd12 || Instr_out !== 32'h2408_0002) begin
      errors++;
      $display("FAIL invalid_const valid=%b bubble=%b exc=%h instr=%h", valid_out, bubble_out, exc_out, Instr_out);
    end
  endtask

  task automatic test_reset_beats_flush;
    drive_cycle(1'b0, 1'b1, 1'b1, 32'h2408_0003, 32'h3020, 1'b1, 1'b1, 5'd4, 32'h0000_00AA);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    checks++;
    if (w_obs !== got) begin errors++; $display("FAIL reset_flush obs=%h exp=%h", w_obs, got); end
    checks++;
    if (bubble_out !== 1'b0 || pc_out !== 32'h3000 || bd_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush_const bubble=%b pc=%h bd=%b exp 0/3000/0", bubble_out, pc_out, bd_out);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 80; i++) begin
      drive_cycle(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  $urandom, $urandom, 1'($urandom), 1'($urandom), EW'($urandom), PW'($urandom));
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if (w_obs !== got) begin errors++; $display("FAIL back_to_back[%0d] obs=%h exp=%h", i, w_obs, got); end
    end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf;
    drive_cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 1'b0, (i >= 4), 32'h100 + i, 32'h3100 + 4 * i, 1'b1, 1'b0, '0, PW'(i));
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if (w_obs !== got) begin errors++; $display("FAIL perf_cycle obs=%h exp=%h", w_obs, got); end
    end
    checks++;
    if (stall_cnt !== 32'd4 || bubble_cnt !== 32'd2 || stall_cnt !== m_stall || bubble_cnt !== m_bubble) begin
      errors++;
      $display("FAIL perf_counts stall=%0d bubble=%0d exp 4/2", stall_cnt, bubble_cnt);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    checks++;
    if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0 || w_obs !== got) begin
      errors++;
      $display("FAIL perf_reset stall=%0d bubble=%0d exp 0/0", stall_cnt, bubble_cnt);
    end
  endtask
`endif

  initial begin
    m_state = '0;
    reset = 1'b0; EN = 1'b0; flush = 1'b0; Instr = '0; pc = '0;
    valid = 1'b0; bd = 1'b0; exc = '0; payload = '0;
    #2;
    test_reset();
    test_load();
    test_stall();
    test_flush_stall();
    test_invalid_load();
    test_reset_beats_flush();
    test_back_to_back();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain left=%0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
